// File: rtl/ifetch_pkg.sv
// Shared types and constants for the miniRV instruction fetch unit.
// The optional IFETCH_ALIGN_CHECK_EN feature uses the HALT state declared here.
package ifetch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HALT  = 2'd2
  } ifetch_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

  localparam logic [31:0] IFETCH_PC_STEP = 32'd4;

  // Fetch addresses are always word aligned; the low two bits are discarded.
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/ifetch_queue.sv
// Prefetch FIFO holding {pc, inst} pairs between the memory side and decode.
// DEPTH must be a power of two so the pointers wrap naturally.
module ifetch_queue
  import ifetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  fetch_entry_t           push_data,
  input  logic                   pop,
  input  logic                   flush,
  output fetch_entry_t           head,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0]   FULL_COUNT = (PW + 1)'(DEPTH);
  localparam logic [PW:0]   CNT_ONE    = (PW + 1)'(1);
  localparam logic [PW-1:0] PTR_ONE    = PW'(1);

  fetch_entry_t  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign do_push = push && (count != FULL_COUNT);
  assign do_pop  = pop && (count != '0);
  assign head    = mem[rd_ptr];

  // Flush only rewinds the pointers; stale data is unreachable once count is zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + PTR_ONE;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ifetch.sv
// miniRV instruction fetch: issues word reads, buffers them, hands {pc, inst} to decode.
// Define IFETCH_ALIGN_CHECK_EN to add the sticky fault output and HALT on misaligned redirects.
module ifetch
  import ifetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_gnt,
  input  logic [31:0] mem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  output logic [31:0] inst_pc,
  output logic [31:0] inst,
  input  logic        inst_ready
`ifdef IFETCH_ALIGN_CHECK_EN
  ,
  output logic        fault
`endif
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  ifetch_state_t state;
  ifetch_state_t state_next;
  logic [31:0]   fetch_pc;
  logic [CW-1:0] count;
  fetch_entry_t  head;
  fetch_entry_t  push_entry;
  logic          accept;
  logic          pop;
  logic          misaligned;

`ifdef IFETCH_ALIGN_CHECK_EN
  assign misaligned = redirect_valid && (redirect_pc[1:0] != 2'b00);
  assign fault      = (state == HALT);
`else
  assign misaligned = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    state_next = misaligned ? HALT : FETCH;
      FETCH:   state_next = misaligned ? HALT : FETCH;
      HALT:    state_next = HALT;
      default: state_next = IDLE;
    endcase
  end

  // Occupancy is taken before any same-cycle pop, so a pop never frees a slot early.
  always_comb begin
    mem_req = 1'b0;
    if (state == FETCH && count < FULL_COUNT && !redirect_valid) begin
      mem_req = 1'b1;
    end
  end

  assign accept     = mem_req && mem_gnt;
  assign pop        = inst_valid && inst_ready && !redirect_valid;
  assign mem_addr   = fetch_pc;
  assign inst_valid = (count != '0);
  assign inst_pc    = head.pc;
  assign inst       = head.inst;

  assign push_entry.pc   = fetch_pc;
  assign push_entry.inst = mem_rdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc <= RESET_PC;
    end else if (redirect_valid) begin
      fetch_pc <= align_word(redirect_pc);
    end else if (accept) begin
      fetch_pc <= fetch_pc + IFETCH_PC_STEP;
    end
  end

  ifetch_queue #(
    .DEPTH(DEPTH)
  ) u_queue (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (accept),
    .push_data(push_entry),
    .pop      (pop),
    .flush    (redirect_valid),
    .head     (head),
    .count    (count)
  );

endmodule

// File: tb/tb_ifetch.sv
// Scoreboard bench for ifetch: a per-cycle reference model checks requests and the
// presented queue head, while scenario tasks check the specific addressed behaviours.
module tb_ifetch;
  import ifetch_pkg::*;

  localparam int          DEPTH    = 2;
  localparam logic [31:0] RESET_PC = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_gnt = 1'b0;
  logic [31:0] mem_rdata;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        inst_valid;
  logic [31:0] inst_pc;
  logic [31:0] inst;
  logic        inst_ready = 1'b0;
`ifdef IFETCH_ALIGN_CHECK_EN
  logic        fault;
`endif

  int tests_run = 0;
  int tests_failed = 0;

  fetch_entry_t sb[$];
  logic [31:0]  exp_pc = RESET_PC;
  bit           running = 1'b0;
  bit           halted = 1'b0;
  bit           exp_req;

  always #5 clk = ~clk;

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
  endfunction

  assign mem_rdata = word_at(mem_addr);

  ifetch #(
    .RESET_PC(RESET_PC),
    .DEPTH   (DEPTH)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .mem_req       (mem_req),
    .mem_addr      (mem_addr),
    .mem_gnt       (mem_gnt),
    .mem_rdata     (mem_rdata),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .inst_valid    (inst_valid),
    .inst_pc       (inst_pc),
    .inst          (inst),
`ifdef IFETCH_ALIGN_CHECK_EN
    .fault         (fault),
`endif
    .inst_ready    (inst_ready)
  );

  // Reference model: compare this cycle's outputs, then apply the coming edge's effects.
  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
      exp_pc  = RESET_PC;
      running = 1'b0;
      halted  = 1'b0;
    end else begin
      exp_req = running && !halted && (sb.size() < DEPTH) && !redirect_valid;
      tests_run++;
      if (mem_req !== exp_req) begin
        tests_failed++;
        $display("[TB] FAIL model_mem_req: got %b expected %b at %0t", mem_req, exp_req, $time);
      end
      if (exp_req) begin
        tests_run++;
        if (mem_addr !== exp_pc) begin
          tests_failed++;
          $display("[TB] FAIL model_mem_addr: got %h expected %h at %0t", mem_addr, exp_pc, $time);
        end
      end
      tests_run++;
      if (inst_valid !== (sb.size() != 0)) begin
        tests_failed++;
        $display("[TB] FAIL model_inst_valid: got %b expected %b at %0t", inst_valid, (sb.size() != 0), $time);
      end
      if (sb.size() != 0) begin
        tests_run++;
        if (inst_pc !== sb[0].pc || inst !== sb[0].inst) begin
          tests_failed++;
          $display("[TB] FAIL model_head: got %h/%h expected %h/%h at %0t", inst_pc, inst, sb[0].pc, sb[0].inst, $time);
        end
      end
`ifdef IFETCH_ALIGN_CHECK_EN
      tests_run++;
      if (fault !== halted) begin
        tests_failed++;
        $display("[TB] FAIL model_fault: got %b expected %b at %0t", fault, halted, $time);
      end
`endif
      if (redirect_valid) begin
        sb.delete();
        exp_pc = {redirect_pc[31:2], 2'b00};
`ifdef IFETCH_ALIGN_CHECK_EN
        if (redirect_pc[1:0] != 2'b00) halted = 1'b1;
`endif
      end else begin
        if (sb.size() != 0 && inst_ready) void'(sb.pop_front());
        if (exp_req && mem_gnt) begin
          fetch_entry_t e;
          e.pc   = exp_pc;
          e.inst = word_at(exp_pc);
          sb.push_back(e);
          exp_pc = exp_pc + 32'd4;
        end
      end
      running = 1'b1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
    #1;
  endtask

  // Asynchronous reset: outputs must take reset values without waiting for a clock edge.
  task automatic apply_reset();
    rst_n = 1'b0;
    #2;
    tests_run++;
    if (mem_req !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_mem_req: got %b expected 0", mem_req); end
    tests_run++;
    if (mem_addr !== RESET_PC) begin tests_failed++; $display("[TB] FAIL reset_mem_addr: got %h expected %h", mem_addr, RESET_PC); end
    tests_run++;
    if (inst_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_inst_valid: got %b expected 0", inst_valid); end
    tests_run++;
    if (inst_pc !== 32'h0 || inst !== 32'h0) begin tests_failed++; $display("[TB] FAIL reset_head: got %h/%h expected 0/0", inst_pc, inst); end
`ifdef IFETCH_ALIGN_CHECK_EN
    tests_run++;
    if (fault !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_fault: got %b expected 0", fault); end
`endif
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    mem_gnt = 1'b1;
    inst_ready = 1'b1;
    redirect_valid = 1'b0;
    #1;
    apply_reset();
  endtask

  task automatic test_sequential();
    logic [31:0] a;
    logic [31:0] p;
    at_neg();
    tests_run++;
    if (mem_req !== 1'b0) begin tests_failed++; $display("[TB] FAIL seq_idle_req: got %b expected 0", mem_req); end
    for (int i = 0; i < 4; i++) begin
      at_neg();
      a = RESET_PC + 32'(4 * i);
      tests_run++;
      if (mem_req !== 1'b1 || mem_addr !== a) begin
        tests_failed++;
        $display("[TB] FAIL seq_addr%0d: got %b/%h expected 1/%h", i, mem_req, mem_addr, a);
      end
      if (i > 0) begin
        p = a - 32'd4;
        tests_run++;
        if (inst_valid !== 1'b1 || inst_pc !== p || inst !== word_at(p)) begin
          tests_failed++;
          $display("[TB] FAIL seq_head%0d: got %b/%h/%h expected 1/%h/%h", i, inst_valid, inst_pc, inst, p, word_at(p));
        end
      end
    end
  endtask

  task automatic test_backpressure();
    int accepts = 0;
    tick();
    inst_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc = 32'h8000_0200;
    tick();
    redirect_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      at_neg();
      if (mem_req && mem_gnt) accepts++;
    end
    tests_run++;
    if (accepts !== 2) begin tests_failed++; $display("[TB] FAIL bp_accepts: got %0d expected 2", accepts); end
    tests_run++;
    if (mem_req !== 1'b0 || mem_addr !== 32'h8000_0208) begin
      tests_failed++;
      $display("[TB] FAIL bp_full_req: got %b/%h expected 0/80000208", mem_req, mem_addr);
    end
    tick();
    inst_ready = 1'b1;
    at_neg();
    tests_run++;
    if (inst_pc !== 32'h8000_0200) begin tests_failed++; $display("[TB] FAIL bp_head0: got %h expected 80000200", inst_pc); end
    at_neg();
    tests_run++;
    if (inst_pc !== 32'h8000_0204 || mem_req !== 1'b1 || mem_addr !== 32'h8000_0208) begin
      tests_failed++;
      $display("[TB] FAIL bp_resume: got %h/%b/%h expected 80000204/1/80000208", inst_pc, mem_req, mem_addr);
    end
    at_neg();
    tests_run++;
    if (inst_pc !== 32'h8000_0208) begin tests_failed++; $display("[TB] FAIL bp_head2: got %h expected 80000208", inst_pc); end
  endtask

  task automatic test_wait_states();
    tick();
    apply_reset();
    tick();
    tick();
    mem_gnt = 1'b0;
    for (int i = 0; i < 3; i++) begin
      at_neg();
      tests_run++;
      if (mem_req !== 1'b1 || mem_addr !== 32'h8000_0004) begin
        tests_failed++;
        $display("[TB] FAIL wait_hold%0d: got %b/%h expected 1/80000004", i, mem_req, mem_addr);
      end
      if (i > 0) begin
        tests_run++;
        if (inst_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL wait_nopush%0d: got %b expected 0", i, inst_valid); end
      end
      tick();
    end
    mem_gnt = 1'b1;
    at_neg();
    tests_run++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h8000_0004) begin
      tests_failed++;
      $display("[TB] FAIL wait_grant: got %b/%h expected 1/80000004", mem_req, mem_addr);
    end
    at_neg();
    tests_run++;
    if (mem_addr !== 32'h8000_0008 || inst_pc !== 32'h8000_0004) begin
      tests_failed++;
      $display("[TB] FAIL wait_after: got %h/%h expected 80000008/80000004", mem_addr, inst_pc);
    end
  endtask

  task automatic test_redirect_full();
    tick();
    inst_ready = 1'b0;
    tick();
    tick();
    tick();
    redirect_valid = 1'b1;
    redirect_pc = 32'h8000_0100;
    at_neg();
    tests_run++;
    if (mem_req !== 1'b0) begin tests_failed++; $display("[TB] FAIL redir_req: got %b expected 0", mem_req); end
    tick();
    redirect_valid = 1'b0;
    inst_ready = 1'b1;
    at_neg();
    tests_run++;
    if (inst_valid !== 1'b0 || mem_req !== 1'b1 || mem_addr !== 32'h8000_0100) begin
      tests_failed++;
      $display("[TB] FAIL redir_next: got %b/%b/%h expected 0/1/80000100", inst_valid, mem_req, mem_addr);
    end
    at_neg();
    tests_run++;
    if (inst_valid !== 1'b1 || inst_pc !== 32'h8000_0100 || inst !== word_at(32'h8000_0100)) begin
      tests_failed++;
      $display("[TB] FAIL redir_head: got %b/%h/%h expected 1/80000100/%h", inst_valid, inst_pc, inst, word_at(32'h8000_0100));
    end
  endtask

  task automatic test_wrap();
    tick();
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    tick();
    redirect_valid = 1'b0;
    at_neg();
    tests_run++;
    if (mem_addr !== 32'hFFFF_FFFC) begin tests_failed++; $display("[TB] FAIL wrap_addr0: got %h expected fffffffc", mem_addr); end
    at_neg();
    tests_run++;
    if (mem_addr !== 32'h0000_0000 || inst_pc !== 32'hFFFF_FFFC) begin
      tests_failed++;
      $display("[TB] FAIL wrap_addr1: got %h/%h expected 00000000/fffffffc", mem_addr, inst_pc);
    end
    at_neg();
    tests_run++;
    if (inst_pc !== 32'h0000_0000) begin tests_failed++; $display("[TB] FAIL wrap_head: got %h expected 00000000", inst_pc); end
  endtask

  task automatic test_misaligned();
    tick();
    redirect_valid = 1'b1;
    redirect_pc = 32'h8000_0102;
    tick();
    redirect_valid = 1'b0;
`ifdef IFETCH_ALIGN_CHECK_EN
    for (int i = 0; i < 6; i++) begin
      at_neg();
      tests_run++;
      if (fault !== 1'b1 || mem_req !== 1'b0 || inst_valid !== 1'b0) begin
        tests_failed++;
        $display("[TB] FAIL halt%0d: got fault %b req %b valid %b expected 1/0/0", i, fault, mem_req, inst_valid);
      end
    end
    tick();
    apply_reset();
`else
    at_neg();
    tests_run++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h8000_0100) begin
      tests_failed++;
      $display("[TB] FAIL misalign_addr: got %b/%h expected 1/80000100", mem_req, mem_addr);
    end
    at_neg();
    tests_run++;
    if (inst_pc !== 32'h8000_0100) begin tests_failed++; $display("[TB] FAIL misalign_head: got %h expected 80000100", inst_pc); end
`endif
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_backpressure();
    test_wait_states();
    test_redirect_full();
    test_wrap();
    test_misaligned();
    tick();
    tick();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not complete by %0t", $time);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
